// File: rtl/uart_getdata.sv
// UART receive path: 2-flop synchronizer, oversampled 8N1 deframer with 2-of-3 majority voting,
// and a single-byte holding register with valid/overrun handshake.
module uart_getdata #(
    parameter int OS_RATE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       os_tick,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(OS_RATE);
    localparam logic [CW-1:0] CntLast = CW'(OS_RATE - 1);
    localparam logic [CW-1:0] CntS0   = CW'(OS_RATE / 2 - 1);
    localparam logic [CW-1:0] CntS1   = CW'(OS_RATE / 2);
    localparam logic [CW-1:0] CntS2   = CW'(OS_RATE / 2 + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
    logic [2:0]      r_bit, w_bit_next;
    logic [7:0]      r_shift, w_shift_next;
    logic [2:0]      r_samp;
    logic            r_rx_meta, r_rx_s, r_rx_prev;
    logic [7:0]      r_rx_data;
    logic            r_rx_done, r_rx_valid, r_frame_err, r_overrun;
    logic            w_fall, w_maj, w_maj_stop, w_load, w_ferr;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_maj      = maj3(r_samp[0], r_samp[1], r_samp[2]);
    // Stop decision happens on the third sample's tick, so the live line replaces samp[2].
    assign w_maj_stop = maj3(r_samp[0], r_samp[1], r_rx_s);
    assign w_cnt_inc  = (r_cnt == CntLast) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_samp  <= 3'b111;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            if (os_tick && r_state != StIdle) begin
                if (r_cnt == CntS0) r_samp[0] <= r_rx_s;
                if (r_cnt == CntS1) r_samp[1] <= r_rx_s;
                if (r_cnt == CntS2) r_samp[2] <= r_rx_s;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (w_fall) w_state_next = StStart;
            end
            StStart: begin
                if (os_tick) begin
                    w_cnt_next = w_cnt_inc;
                    if (r_cnt == CntLast) begin
                        w_bit_next   = '0;
                        w_state_next = w_maj ? StIdle : StData;
                    end
                end
            end
            StData: begin
                if (os_tick) begin
                    w_cnt_next = w_cnt_inc;
                    if (r_cnt == CntLast) begin
                        w_shift_next = {w_maj, r_shift[7:1]};
                        if (r_bit == 3'd7) w_state_next = StStop;
                        else               w_bit_next   = r_bit + 1'b1;
                    end
                end
            end
            StStop: begin
                if (os_tick) begin
                    w_cnt_next = w_cnt_inc;
                    if (r_cnt == CntS2) begin
                        w_cnt_next = '0;
                        if (w_maj_stop) begin
                            w_load       = 1'b1;
                            w_state_next = StIdle;
                        end else begin
                            w_ferr       = 1'b1;
                            w_state_next = StWaitHigh;
                        end
                    end
                end
            end
            StWaitHigh: begin
                w_cnt_next = '0;
                if (r_rx_s) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_done   <= w_load;
            r_frame_err <= w_ferr;
            if (w_load) r_rx_data <= r_shift;
            r_rx_valid <= w_load | (r_rx_valid & ~rx_ack);
            // Set beats clear; ack with nothing held is ignored.
            if (w_load && r_rx_valid && !rx_ack) r_overrun <= 1'b1;
            else if (rx_ack && r_rx_valid)       r_overrun <= 1'b0;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != StIdle);

endmodule

// File: doc/uart_getdata.md
UART_GETDATA -- requirements
Module: uart_getdata

Interface
REQ-001 SHALL have parameter OS_RATE, default 16, meaning os_tick pulses per bit period (values 8..16, even).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port os_tick  input  1  one-clk pulse at OS_RATE x baud.
REQ-006 SHALL have port rx_ack  input  1  consumer has taken rx_data.
REQ-007 SHALL have port rx_data  output  8  last received byte.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse, good byte received.
REQ-009 SHALL have port rx_valid  output  1  byte held, not yet acknowledged.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  sticky, byte completed while rx_valid=1.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only; it SHALL reset to 1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 SHALL use a tick counter cnt (0..OS_RATE-1) advanced only on os_tick, and a bit index 0..7.
REQ-016 SHALL sample rx_s on os_tick at cnt = OS_RATE/2-1, OS_RATE/2, OS_RATE/2+1; the bit value SHALL be the 2-of-3 majority.
REQ-017 IDLE: on rx_s falling edge (previous 1, current 0), SHALL go to START with cnt=0, independent of os_tick.
REQ-018 START: at the os_tick where cnt=OS_RATE-1, if majority=0 SHALL go to DATA with cnt=0 and bit index 0; otherwise SHALL go to IDLE (glitch rejected, no output activity).
REQ-019 DATA: at cnt=OS_RATE-1, SHALL shift the majority bit into the shift register LSB-first; after bit index 7 SHALL go to STOP with cnt=0.
REQ-020 STOP: decision SHALL be made at the os_tick where cnt=OS_RATE/2+1 (mid-bit, for resynchronisation margin).
REQ-021 STOP with majority=1: rx_data SHALL load the shift register, rx_done SHALL pulse on the next clk edge, and the FSM SHALL go to IDLE.
REQ-022 STOP with majority=0: frame_err SHALL pulse for one clk, rx_data, rx_valid and rx_done SHALL be unchanged, and the FSM SHALL go to WAIT_HIGH.
REQ-023 WAIT_HIGH: SHALL go to IDLE only when rx_s=1; a held-low line (break) SHALL NOT produce further frames.
REQ-024 rx_valid SHALL be set with rx_done and cleared by rx_ack; if both occur in one cycle, rx_valid SHALL stay 1.
REQ-025 overrun SHALL be set when rx_done fires while rx_valid=1 and rx_ack=0; the new byte SHALL overwrite rx_data.
REQ-026 overrun SHALL be cleared by rx_ack unless a set condition occurs in the same cycle, in which case set wins.
REQ-027 rx_ack while rx_valid=0 SHALL have no effect.
REQ-028 A byte SHALL be reported no later than OS_RATE*9.5+3 os_tick periods + 4 clk after the start edge on rx.

Reset
REQ-029 While rst_n=0: state=IDLE, cnt=0, bit index=0, shift register=0, rx_data=8'h00, rx_done=0, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-030 Reset mid-frame SHALL abort the frame; after release the FSM SHALL wait for a new falling edge and SHALL NOT report the partial byte.

Verification (clk 50 MHz, os_tick every 27 clk, OS_RATE=16, 8N1 stimulus at matching bit time)
REQ-031 Send 0x55, then 0xA3 with rx_ack after each -> rx_data=0x55 then 0xA3, one rx_done each, frame_err=0, overrun=0.
REQ-032 Drive rx low for 4 os_tick periods, then high -> FSM returns to IDLE, no rx_done, no frame_err, busy back to 0.
REQ-033 Send 0x3C with stop bit=0, then hold rx low 20 bit times -> one frame_err pulse, rx_data unchanged, no rx_done, busy=1 until rx returns high.
REQ-034 Send 0x12 then 0x34 without rx_ack -> overrun=1 after second byte, rx_data=0x34; one rx_ack -> rx_valid=0, overrun=0.
REQ-035 Send 0x81 with a one-os_tick-wide inverted glitch at the centre of bit 3 -> rx_data=0x81 (majority vote).
REQ-036 Assert rst_n=0 during bit 4 of 0xF0, release, then send 0x0F -> only 0x0F reported, all outputs at reset values in between.
